// File: rtl/instr_queue_mt.sv
// Multi-thread instruction queue: one circular FIFO per thread, multi-lane write/read,
// per-thread occupancy, and a post-reset sweep that zeroes the storage.
module instr_queue_mt #(
  parameter int unsigned WIDTH        = 80,
  parameter int unsigned OTHER        = 64,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned NTHREAD      = 2,
  parameter int unsigned WR_PORTS     = 16,
  parameter int unsigned RD_PORTS     = 11,
  parameter int unsigned STALL_MARGIN = 0,
  localparam int unsigned TW = (NTHREAD > 1) ? $clog2(NTHREAD) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_wen,
  input  logic [TW-1:0]               write_thread,
  input  logic [WR_PORTS-1:0]         write_instrEn,
  input  logic [WR_PORTS*WIDTH-1:0]   write_instr0,
  input  logic [WR_PORTS*OTHER-1:0]   write_other0,
  output logic                        doFStall,
  input  logic                        except,
  input  logic [TW-1:0]               except_thread,
  input  logic [TW-1:0]               read_thread,
  input  logic                        read_clkEn,
  input  logic [RD_PORTS-1:0]         read_instrEn,
  output logic [RD_PORTS-1:0]         read_avail,
  output logic [RD_PORTS*WIDTH-1:0]   read_instr0,
  output logic [RD_PORTS*OTHER-1:0]   read_other0,
  output logic [NTHREAD*CW-1:0]       busy_out
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned EW  = WIDTH + OTHER;
  localparam int unsigned LIM = DEPTH - WR_PORTS - STALL_MARGIN;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [PW-1:0] init_idx, init_idx_nxt;
  logic          run;

  logic [PW-1:0] head [NTHREAD];
  logic [PW-1:0] tail [NTHREAD];
  logic [CW-1:0] busy [NTHREAD];
  logic [EW-1:0] mem  [NTHREAD][DEPTH];

  logic          wr_tv, rd_tv, ex_tv;
  logic [TW-1:0] wr_t, rd_t;
  logic [CW-1:0] busy_w, busy_r;
  logic [CW-1:0] nw, nr;
  logic          wr_lead, rd_lead;
  logic          wr_acc, pop_en, flush;
  logic [NTHREAD-1:0] wr_sel, pop_sel, fl_sel;
  logic [EW-1:0] rd_ent;

  // Init/run state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  // Init sweep walks every index once, then stays in RUN until reset
  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    case (state)
      ST_INIT: begin
        init_idx_nxt = init_idx + PW'(1);
        if (init_idx == PW'(DEPTH - 1)) state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign run = (state == ST_RUN);

  // Thread qualification and stall from registered occupancy only
  always_comb begin
    wr_tv    = (32'(write_thread) < NTHREAD);
    rd_tv    = (32'(read_thread) < NTHREAD);
    ex_tv    = (32'(except_thread) < NTHREAD);
    wr_t     = wr_tv ? write_thread : '0;
    rd_t     = rd_tv ? read_thread : '0;
    busy_w   = busy[wr_t];
    busy_r   = rd_tv ? busy[rd_t] : '0;
    doFStall = !run || !wr_tv || (32'(busy_w) > LIM);
  end

  // Leading-ones count of the write lane enables
  always_comb begin
    nw      = '0;
    wr_lead = 1'b1;
    for (int unsigned i = 0; i < WR_PORTS; i++) begin
      if (wr_lead && write_instrEn[i]) nw = nw + CW'(1);
      else wr_lead = 1'b0;
    end
  end

  // Head-of-queue lanes for the read thread, zero where not present
  always_comb begin
    read_avail  = '0;
    read_instr0 = '0;
    read_other0 = '0;
    rd_ent      = '0;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      if (run && rd_tv && (32'(busy_r) > r)) begin
        read_avail[r] = 1'b1;
        rd_ent = mem[rd_t][head[rd_t] + PW'(r)];
        read_instr0[r*WIDTH +: WIDTH] = rd_ent[EW-1:OTHER];
        read_other0[r*OTHER +: OTHER] = rd_ent[OTHER-1:0];
      end
    end
  end

  // Leading-ones count of requested lanes that are actually available
  always_comb begin
    nr      = '0;
    rd_lead = 1'b1;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      if (rd_lead && read_instrEn[r] && read_avail[r]) nr = nr + CW'(1);
      else rd_lead = 1'b0;
    end
  end

  // Per-thread write/pop/flush selects; flush drops same-thread write and pop
  always_comb begin
    wr_acc = write_wen && !doFStall && run && wr_tv;
    pop_en = read_clkEn && run && rd_tv;
    flush  = except && run && ex_tv;
    for (int unsigned t = 0; t < NTHREAD; t++) begin
      fl_sel[t]  = flush && (32'(except_thread) == t);
      wr_sel[t]  = wr_acc && (32'(write_thread) == t) && !fl_sel[t];
      pop_sel[t] = pop_en && (32'(read_thread) == t) && !fl_sel[t];
    end
  end

  // Pointer and occupancy update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NTHREAD; t++) begin
        head[t] <= '0;
        tail[t] <= '0;
        busy[t] <= '0;
      end
    end else begin
      for (int unsigned t = 0; t < NTHREAD; t++) begin
        if (fl_sel[t]) begin
          head[t] <= '0;
          tail[t] <= '0;
          busy[t] <= '0;
        end else begin
          if (wr_sel[t])  tail[t] <= tail[t] + PW'(nw);
          if (pop_sel[t]) head[t] <= head[t] + PW'(nr);
          busy[t] <= busy[t] + (wr_sel[t] ? nw : '0) - (pop_sel[t] ? nr : '0);
        end
      end
    end
  end

  // Entry storage: zero sweep during init, lane writes during run
  always_ff @(posedge clk) begin
    if (!run) begin
      for (int unsigned t = 0; t < NTHREAD; t++) mem[t][init_idx] <= '0;
    end else begin
      for (int unsigned t = 0; t < NTHREAD; t++) begin
        if (wr_sel[t]) begin
          for (int unsigned i = 0; i < WR_PORTS; i++) begin
            if (CW'(i) < nw)
              mem[t][tail[t] + PW'(i)] <= {write_instr0[i*WIDTH +: WIDTH], write_other0[i*OTHER +: OTHER]};
          end
        end
      end
    end
  end

  // Occupancy output, one CW-bit field per thread
  always_comb begin
    busy_out = '0;
    for (int unsigned t = 0; t < NTHREAD; t++) busy_out[t*CW +: CW] = busy[t];
  end

endmodule

// File: tb/tb_instr_queue_mt.sv
// Testbench for instr_queue_mt: directed vector table, wrap sequence, random traffic
// against a queue-based reference, and reset behaviour.
module tb_instr_queue_mt;

  localparam int unsigned WIDTH = 80;
  localparam int unsigned OTHER = 64;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NT    = 2;
  localparam int unsigned WR    = 16;
  localparam int unsigned RD    = 11;
  localparam int unsigned SM    = 0;
  localparam int unsigned TW    = 1;
  localparam int unsigned CW    = 7;
  localparam int unsigned EW    = WIDTH + OTHER;

  logic                  clk;
  logic                  rst;
  logic                  write_wen;
  logic [TW-1:0]         write_thread;
  logic [WR-1:0]         write_instrEn;
  logic [WR*WIDTH-1:0]   write_instr0;
  logic [WR*OTHER-1:0]   write_other0;
  logic                  doFStall;
  logic                  except;
  logic [TW-1:0]         except_thread;
  logic [TW-1:0]         read_thread;
  logic                  read_clkEn;
  logic [RD-1:0]         read_instrEn;
  logic [RD-1:0]         read_avail;
  logic [RD*WIDTH-1:0]   read_instr0;
  logic [RD*OTHER-1:0]   read_other0;
  logic [NT*CW-1:0]      busy_out;

  instr_queue_mt dut (
    .clk(clk), .rst(rst),
    .write_wen(write_wen), .write_thread(write_thread), .write_instrEn(write_instrEn),
    .write_instr0(write_instr0), .write_other0(write_other0), .doFStall(doFStall),
    .except(except), .except_thread(except_thread),
    .read_thread(read_thread), .read_clkEn(read_clkEn), .read_instrEn(read_instrEn),
    .read_avail(read_avail), .read_instr0(read_instr0), .read_other0(read_other0),
    .busy_out(busy_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain queues of {instr, other} per thread
  typedef logic [EW-1:0] ent_t;
  ent_t mq [NT][$];
  int   init_cnt;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic        wen;
    logic        wt;
    logic [15:0] wm;
    logic [15:0] dbase;
    logic        rclk;
    logic        rt;
    logic [10:0] ren;
    logic        ex;
    logic        et;
    logic        e_stall;
    logic [10:0] e_avail;
    logic [15:0] e_lane0;
    logic [6:0]  e_b0;
    logic [6:0]  e_b1;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lead1(input logic [31:0] v, input int n);
    int  c;
    logic go;
    c  = 0;
    go = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (go && v[i]) c++;
      else go = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [31:0] mask_gen(input int n);
    int k;
    logic [31:0] m;
    k = $urandom_range(0, n);
    m = (32'd1 << k) - 32'd1;
    if (k < n - 1) m = m | ($urandom << (k + 1));
    return m;
  endfunction

  task automatic set_data_base(input logic [15:0] b);
    for (int i = 0; i < WR; i++) begin
      write_instr0[i*WIDTH +: WIDTH] = WIDTH'(b + 16'(i));
      write_other0[i*OTHER +: OTHER] = OTHER'(b + 16'(i)) ^ 64'hA5A5_5A5A_0F0F_F0F0;
    end
  endtask

  task automatic set_data_rand();
    for (int i = 0; i < WR; i++) begin
      write_instr0[i*WIDTH +: WIDTH] = WIDTH'({$urandom, $urandom, $urandom});
      write_other0[i*OTHER +: OTHER] = OTHER'({$urandom, $urandom});
    end
  endtask

  task automatic drive(input logic wen, input logic [TW-1:0] wt, input logic [WR-1:0] wm,
                       input logic rclk, input logic [TW-1:0] rt, input logic [RD-1:0] ren,
                       input logic ex, input logic [TW-1:0] et);
    write_wen     = wen;
    write_thread  = wt;
    write_instrEn = wm;
    read_clkEn    = rclk;
    read_thread   = rt;
    read_instrEn  = ren;
    except        = ex;
    except_thread = et;
  endtask

  // Compare outputs with the reference, clock once, then advance the reference
  task automatic cycle();
    logic                in_init;
    logic                e_stall;
    logic [RD-1:0]       e_avail;
    logic [RD*WIDTH-1:0] e_instr;
    logic [RD*OTHER-1:0] e_other;
    logic [NT*CW-1:0]    e_busy;
    ent_t                e;
    int                  szw, szr, nw, nr;
    in_init = (init_cnt < int'(DEPTH));
    szw = mq[write_thread].size();
    szr = mq[read_thread].size();
    e_stall = in_init || (szw > int'(DEPTH - WR - SM));
    e_avail = '0;
    e_instr = '0;
    e_other = '0;
    for (int r = 0; r < int'(RD); r++) begin
      if (!in_init && r < szr) begin
        e = mq[read_thread][r];
        e_avail[r] = 1'b1;
        e_instr[r*WIDTH +: WIDTH] = e[EW-1:OTHER];
        e_other[r*OTHER +: OTHER] = e[OTHER-1:0];
      end
    end
    for (int t = 0; t < int'(NT); t++) e_busy[t*CW +: CW] = CW'(mq[t].size());
    chk("stall", 1024'(doFStall), 1024'(e_stall));
    chk("avail", 1024'(read_avail), 1024'(e_avail));
    chk("instr", 1024'(read_instr0), 1024'(e_instr));
    chk("other", 1024'(read_other0), 1024'(e_other));
    chk("busy", 1024'(busy_out), 1024'(e_busy));
    nw = lead1(32'(write_instrEn), WR);
    nr = lead1(32'(read_instrEn & e_avail), RD);
    @(posedge clk);
    if (in_init) begin
      init_cnt++;
    end else begin
      if (except) mq[except_thread].delete();
      if (read_clkEn && !(except && except_thread == read_thread))
        for (int i = 0; i < nr; i++) e = mq[read_thread].pop_front();
      if (write_wen && !e_stall && !(except && except_thread == write_thread))
        for (int i = 0; i < nw; i++)
          mq[write_thread].push_back({write_instr0[i*WIDTH +: WIDTH], write_other0[i*OTHER +: OTHER]});
    end
    @(negedge clk);
  endtask

  task automatic step(input logic wen, input logic [TW-1:0] wt, input logic [WR-1:0] wm,
                      input logic rclk, input logic [TW-1:0] rt, input logic [RD-1:0] ren,
                      input logic ex, input logic [TW-1:0] et);
    drive(wen, wt, wm, rclk, rt, ren, ex, et);
    #1;
    cycle();
  endtask

  task automatic rand_step();
    set_data_rand();
    step(($urandom_range(0, 9) < 7), TW'($urandom_range(0, NT - 1)), WR'(mask_gen(WR)),
         ($urandom_range(0, 9) < 6), TW'($urandom_range(0, NT - 1)), RD'(mask_gen(RD)),
         ($urandom_range(0, 39) == 0), TW'($urandom_range(0, NT - 1)));
  endtask

  // Assert reset at a falling edge, check reset outputs, release two cycles later
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_busy", 1024'(busy_out), 1024'(0));
    chk("rst_stall", 1024'(doFStall), 1024'(1));
    chk("rst_avail", 1024'(read_avail), 1024'(0));
    for (int t = 0; t < int'(NT); t++) mq[t].delete();
    init_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Init phase with writes, pops and flushes requested throughout; all must be ignored
  task automatic run_init();
    for (int c = 0; c < int'(DEPTH); c++) begin
      set_data_rand();
      step(1'b1, TW'(c % 2), '1, 1'b1, TW'(c % 2), '1, 1'b1, TW'(c % 2));
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("init_done_stall", 1024'(doFStall), 1024'(0));
    chk("init_done_busy", 1024'(busy_out), 1024'(0));
    chk("init_done_instr", 1024'(read_instr0), 1024'(0));
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    init_cnt = 0;
    rst      = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    write_instr0 = '0;
    write_other0 = '0;

    //         wen wt wm       dbase    rclk rt ren     ex et stall avail   lane0    b0 b1
    tbl[0]  = '{1, 0, 16'h001F, 16'h0001, 0, 0, 11'h000, 0, 0, 0, 11'h000, 16'h0000, 5, 0};
    tbl[1]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 11'h007, 0, 0, 0, 11'h01F, 16'h0001, 2, 0};
    tbl[2]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 11'h000, 0, 0, 0, 11'h003, 16'h0004, 2, 0};
    tbl[3]  = '{1, 1, 16'hFFFF, 16'h0100, 0, 1, 11'h000, 0, 0, 0, 11'h000, 16'h0000, 2, 16};
    tbl[4]  = '{1, 1, 16'hFFFF, 16'h0200, 0, 1, 11'h000, 0, 0, 0, 11'h7FF, 16'h0100, 2, 32};
    tbl[5]  = '{1, 1, 16'hFFFF, 16'h0300, 0, 1, 11'h000, 0, 0, 0, 11'h7FF, 16'h0100, 2, 48};
    tbl[6]  = '{1, 1, 16'hFFFF, 16'h0400, 0, 1, 11'h000, 0, 0, 0, 11'h7FF, 16'h0100, 2, 64};
    tbl[7]  = '{1, 1, 16'hFFFF, 16'h0500, 0, 1, 11'h000, 0, 0, 1, 11'h7FF, 16'h0100, 2, 64};
    tbl[8]  = '{1, 0, 16'h000B, 16'h0600, 0, 0, 11'h000, 0, 0, 0, 11'h003, 16'h0004, 4, 64};
    tbl[9]  = '{1, 0, 16'h000F, 16'h0700, 1, 1, 11'h007, 1, 0, 0, 11'h7FF, 16'h0100, 0, 61};
    tbl[10] = '{1, 1, 16'hFFFF, 16'h0800, 1, 1, 11'h7FF, 0, 0, 1, 11'h7FF, 16'h0103, 0, 50};
    tbl[11] = '{1, 1, 16'hFFFF, 16'h0900, 1, 1, 11'h7FF, 0, 0, 1, 11'h7FF, 16'h010E, 0, 39};
    tbl[12] = '{1, 1, 16'h00FF, 16'h0A00, 1, 1, 11'h001, 0, 0, 0, 11'h7FF, 16'h0209, 0, 46};
    tbl[13] = '{0, 1, 16'h0000, 16'h0000, 1, 1, 11'h7FB, 0, 0, 0, 11'h7FF, 16'h020A, 0, 44};
    tbl[14] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 11'h7FF, 0, 0, 0, 11'h000, 16'h0000, 0, 44};

    @(negedge clk);
    do_reset();
    run_init();

    // Directed vectors
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].wen, tbl[k].wt, tbl[k].wm, tbl[k].rclk, tbl[k].rt, tbl[k].ren, tbl[k].ex, tbl[k].et);
      set_data_base(tbl[k].dbase);
      #1;
      chk($sformatf("v%0d_stall", k), 1024'(doFStall), 1024'(tbl[k].e_stall));
      chk($sformatf("v%0d_avail", k), 1024'(read_avail), 1024'(tbl[k].e_avail));
      chk($sformatf("v%0d_lane0", k), 1024'(read_instr0[WIDTH-1:0]), 1024'(tbl[k].e_lane0));
      cycle();
      chk($sformatf("v%0d_busy0", k), 1024'(busy_out[CW-1:0]), 1024'(tbl[k].e_b0));
      chk($sformatf("v%0d_busy1", k), 1024'(busy_out[2*CW-1:CW]), 1024'(tbl[k].e_b1));
    end

    // Wrap: move thread 0 pointers to 60, then write 8 lanes across the 63->0 boundary
    for (int k = 0; k < 3; k++) begin
      set_data_base(16'(16'h0C00 + 16'(k * 16)));
      step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    set_data_base(16'h0C30);
    step(1'b1, 1'b0, 16'h0FFF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 11'h7FF, 1'b0, 1'b0);
    chk("wrap_empty", 1024'(busy_out[CW-1:0]), 1024'(0));
    set_data_base(16'h0B00);
    step(1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("wrap_avail", 1024'(read_avail), 1024'(11'h0FF));
    for (int i = 0; i < 8; i++)
      chk($sformatf("wrap_lane%0d", i), 1024'(read_instr0[i*WIDTH +: WIDTH]), 1024'(16'h0B00 + 16'(i)));
    cycle();

    // Random traffic
    for (int k = 0; k < 800; k++) rand_step();

    // Reset in the middle of traffic discards everything and re-runs the sweep
    do_reset();
    run_init();
    for (int k = 0; k < 100; k++) rand_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
